// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: 32-entry integer register file with writeback
// bypass, feeding a registered operand latch to the ALU.
module operand_fetch_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CTRL_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] rs1_addr,
   input  logic [ADDR_WIDTH-1:0] rs2_addr,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  use_imm,
   input  logic [DATA_WIDTH-1:0] imm,
   input  logic [CTRL_WIDTH-1:0] alu_ctrl_in,
   input  logic                  wb_en,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] data_r1,
   output logic [DATA_WIDTH-1:0] data_r2,
   output logic [CTRL_WIDTH-1:0] ALUControl,
   output logic [ADDR_WIDTH-1:0] rd_out
);

   localparam int NREGS = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [NREGS];

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] r1_q, r1_d;
   logic [DATA_WIDTH-1:0] r2_q, r2_d;
   logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
   logic [ADDR_WIDTH-1:0] rd_q, rd_d;

   logic                  accept;
   logic                  wb_hit1;
   logic                  wb_hit2;
   logic [DATA_WIDTH-1:0] src1;
   logic [DATA_WIDTH-1:0] src2;
   logic [DATA_WIDTH-1:0] op2;

   // Register array; x0 is never written so it reads as zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wb_en && (wb_addr != '0)) begin
         regs_q[wb_addr] <= wb_data;
      end
   end

   // Source read with same-cycle writeback bypass
   always_comb begin
      wb_hit1 = wb_en && (wb_addr == rs1_addr);
      wb_hit2 = wb_en && (wb_addr == rs2_addr);
      src1    = '0;
      src2    = '0;
      if (rs1_addr == '0) begin
         src1 = '0;
      end else if (wb_hit1) begin
         src1 = wb_data;
      end else begin
         src1 = regs_q[rs1_addr];
      end
      if (rs2_addr == '0) begin
         src2 = '0;
      end else if (wb_hit2) begin
         src2 = wb_data;
      end else begin
         src2 = regs_q[rs2_addr];
      end
      op2 = use_imm ? imm : src2;
   end

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Next state of the operand latch: load, drain, or hold
   always_comb begin
      valid_d = valid_q;
      r1_d    = r1_q;
      r2_d    = r2_q;
      ctrl_d  = ctrl_q;
      rd_d    = rd_q;
      if (accept) begin
         valid_d = 1'b1;
         r1_d    = src1;
         r2_d    = op2;
         ctrl_d  = alu_ctrl_in;
         rd_d    = rd_addr;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // Operand latch registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         r1_q    <= '0;
         r2_q    <= '0;
         ctrl_q  <= '0;
         rd_q    <= '0;
      end else begin
         valid_q <= valid_d;
         r1_q    <= r1_d;
         r2_q    <= r2_d;
         ctrl_q  <= ctrl_d;
         rd_q    <= rd_d;
      end
   end

   assign out_valid  = valid_q;
   assign data_r1    = r1_q;
   assign data_r2    = r2_q;
   assign ALUControl = ctrl_q;
   assign rd_out     = rd_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: vector table plus
// hand-written reset, streaming and stall sequences.
module tb_operand_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic        use_imm;
   logic [31:0] imm;
   logic [0:0]  alu_ctrl_in;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data_r1, data_r2;
   logic [0:0]  ALUControl;
   logic [4:0]  rd_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   operand_fetch_stage dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .use_imm(use_imm), .imm(imm), .alu_ctrl_in(alu_ctrl_in),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .data_r1(data_r1), .data_r2(data_r2),
      .ALUControl(ALUControl), .rd_out(rd_out)
   );

   typedef struct {
      logic        wen;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        iv;
      logic [4:0]  r1, r2, rd;
      logic        ui;
      logic [31:0] im;
      logic        c;
      logic        ordy;
      logic        e_rdy;
      logic        e_ov;
      logic [31:0] e_d1, e_d2;
      logic        e_c;
      logic [4:0]  e_rd;
   } vec_t;

   vec_t tv [12];

   function automatic vec_t mk(
      input logic wen, input logic [4:0] wa, input logic [31:0] wd,
      input logic iv, input logic [4:0] r1, input logic [4:0] r2,
      input logic [4:0] rd, input logic ui, input logic [31:0] im,
      input logic c, input logic ordy,
      input logic e_rdy, input logic e_ov,
      input logic [31:0] e_d1, input logic [31:0] e_d2,
      input logic e_c, input logic [4:0] e_rd);
      vec_t v;
      v.wen = wen; v.wa = wa; v.wd = wd; v.iv = iv;
      v.r1 = r1; v.r2 = r2; v.rd = rd; v.ui = ui; v.im = im;
      v.c = c; v.ordy = ordy; v.e_rdy = e_rdy; v.e_ov = e_ov;
      v.e_d1 = e_d1; v.e_d2 = e_d2; v.e_c = e_c; v.e_rd = e_rd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      in_valid = 0; rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
      use_imm = 0; imm = 0; alu_ctrl_in = 0;
      wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
   endtask

   task automatic chk_out(input string tag, input logic ov,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic c, input logic [4:0] rd);
      chk({tag, ".ov"}, {31'b0, out_valid}, {31'b0, ov});
      chk({tag, ".d1"}, data_r1, d1);
      chk({tag, ".d2"}, data_r2, d2);
      chk({tag, ".ctl"}, {31'b0, ALUControl}, {31'b0, c});
      chk({tag, ".rd"}, {27'b0, rd_out}, {27'b0, rd});
   endtask

   initial begin
      // write x3, read back, x0 write ignored while reading x0
      tv[0]  = mk(1, 3, 32'hE, 0, 0, 0, 0, 0, 0, 0, 1,
                  1, 0, 0, 0, 0, 0);
      tv[1]  = mk(0, 0, 0, 1, 3, 0, 7, 0, 0, 1, 1,
                  1, 1, 32'hE, 0, 1, 7);
      tv[2]  = mk(1, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 0, 0, 0, 1,
                  1, 1, 0, 0, 0, 1);
      // drain: outputs hold
      tv[3]  = mk(1, 4, 32'h1, 0, 0, 0, 0, 0, 0, 0, 1,
                  1, 0, 0, 0, 0, 1);
      // bypass on rs2 while x4 written
      tv[4]  = mk(1, 4, 32'hF, 1, 3, 4, 4, 0, 0, 1, 1,
                  1, 1, 32'hE, 32'hF, 1, 4);
      // array holds new x4
      tv[5]  = mk(0, 0, 0, 1, 4, 3, 5, 0, 0, 0, 1,
                  1, 1, 32'hF, 32'hE, 0, 5);
      // immediate select
      tv[6]  = mk(0, 0, 0, 1, 4, 3, 6, 1, 32'hFFFFFFF0, 1, 1,
                  1, 1, 32'hF, 32'hFFFFFFF0, 1, 6);
      // stall 3 cycles presenting B; x3 rewritten during stall
      tv[7]  = mk(1, 3, 32'h55, 1, 3, 4, 9, 0, 0, 0, 0,
                  0, 1, 32'hF, 32'hFFFFFFF0, 1, 6);
      tv[8]  = mk(0, 0, 0, 1, 3, 4, 9, 0, 0, 0, 0,
                  0, 1, 32'hF, 32'hFFFFFFF0, 1, 6);
      tv[9]  = mk(0, 0, 0, 1, 3, 4, 9, 0, 0, 0, 0,
                  0, 1, 32'hF, 32'hFFFFFFF0, 1, 6);
      // release: B latched back-to-back
      tv[10] = mk(0, 0, 0, 1, 3, 4, 9, 0, 0, 0, 1,
                  1, 1, 32'h55, 32'hF, 0, 9);
      tv[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                  1, 0, 32'h55, 32'hF, 0, 9);

      idle_inputs();
      rst = 1;
      #12;
      chk_out("rst", 0, 0, 0, 0, 0);
      chk("rst.rdy", {31'b0, in_ready}, 1);
      @(negedge clk);
      rst = 0;

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         wb_en = tv[i].wen; wb_addr = tv[i].wa; wb_data = tv[i].wd;
         in_valid = tv[i].iv; rs1_addr = tv[i].r1;
         rs2_addr = tv[i].r2; rd_addr = tv[i].rd;
         use_imm = tv[i].ui; imm = tv[i].im;
         alu_ctrl_in = tv[i].c; out_ready = tv[i].ordy;
         #1;
         chk($sformatf("v%0d.rdy", i), {31'b0, in_ready},
             {31'b0, tv[i].e_rdy});
         @(posedge clk);
         #1;
         chk_out($sformatf("v%0d", i), tv[i].e_ov, tv[i].e_d1,
                 tv[i].e_d2, tv[i].e_c, tv[i].e_rd);
      end

      // stream 4 instructions, out_valid high 4 cycles then low
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         idle_inputs();
         if (i < 4) begin
            in_valid = 1; rs1_addr = 4; rd_addr = 5'(i + 10);
         end
         @(posedge clk);
         #1;
         chk($sformatf("stream%0d.ov", i), {31'b0, out_valid},
             (i < 4) ? 32'd1 : 32'd0);
         if (i < 4)
            chk($sformatf("stream%0d.rd", i), {27'b0, rd_out}, i + 10);
      end

      // async reset mid-transaction
      @(negedge clk);
      idle_inputs();
      wb_en = 1; wb_addr = 5; wb_data = 32'h1234;
      @(negedge clk);
      idle_inputs();
      in_valid = 1; rs1_addr = 5; rs2_addr = 3; out_ready = 0;
      @(posedge clk);
      #1;
      chk_out("pre", 1, 32'h1234, 32'h55, 0, 0);
      #2;
      rst = 1;
      #1;
      chk_out("arst", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 0;
      idle_inputs();
      in_valid = 1; rs1_addr = 5; rs2_addr = 3; rd_addr = 2;
      @(posedge clk);
      #1;
      chk_out("post", 1, 0, 0, 0, 2);

      @(negedge clk);
      idle_inputs();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Register-file plus operand-latch stage directly upstream of the ALU.
- Holds the 32 x 32-bit RV32I integer registers and accepts decoded rs1/rs2/rd fields from decode.
- Produces registered data_r1/data_r2/ALUControl for the ALU through a valid/ready handshake.
- Takes writeback from the end of the pipeline, with same-cycle write-to-read bypass.

Parameters:
- DATA_WIDTH, 32, register and operand width.
- ADDR_WIDTH, 5, register index width; register count is 2**ADDR_WIDTH.
- CTRL_WIDTH, 1, width of the ALU control field passed through.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- rs1_addr  in  ADDR_WIDTH  source register 1 index
- rs2_addr  in  ADDR_WIDTH  source register 2 index
- rd_addr  in  ADDR_WIDTH  destination index, passed through
- use_imm  in  1  select imm instead of rs2 for operand 2
- imm  in  DATA_WIDTH  sign-extended immediate from decode
- alu_ctrl_in  in  CTRL_WIDTH  ALU operation, passed through
- wb_en  in  1  writeback enable
- wb_addr  in  ADDR_WIDTH  writeback register index
- wb_data  in  DATA_WIDTH  writeback data
- out_valid  out  1  operands valid to ALU
- out_ready  in  1  ALU consumes this cycle
- data_r1  out  DATA_WIDTH  registered operand 1
- data_r2  out  DATA_WIDTH  registered operand 2 (rs2 or imm)
- ALUControl  out  CTRL_WIDTH  registered ALU control
- rd_out  out  ADDR_WIDTH  registered destination index

Behaviour:
- Reset (async, rst=1):
  - all 32 registers = 0;
  - out_valid = 0; data_r1, data_r2, ALUControl, rd_out = 0.
  - Takes effect immediately, regardless of clk.
  - Any held transaction is dropped.
  - No writes occur while rst=1.
- Register file:
  - Index 0 always reads 0.
  - Writes with wb_addr=0 are ignored.
  - Write happens on the rising edge when wb_en=1.
- Combinational read with bypass:
  - src1 = (rs1_addr==0) ? 0 : (wb_en && wb_addr==rs1_addr) ? wb_data : regs[rs1_addr].
  - src2 is formed the same way from rs2_addr.
  - op2 = use_imm ? imm : src2.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no combinational path from in_valid to in_ready).
  - Accept = in_valid && in_ready. On accept at the edge:
    - data_r1 <= src1;
    - data_r2 <= op2;
    - ALUControl <= alu_ctrl_in;
    - rd_out <= rd_addr;
    - out_valid <= 1.
  - If out_valid && out_ready && !in_valid, then out_valid <= 0 and the data outputs hold their last values.
  - If out_valid && out_ready && in_valid: back-to-back, new operands latched, out_valid stays 1.
  - If out_valid && !out_ready: all outputs held stable, in_ready=0, input ignored.
- Latency and throughput:
  - 1 cycle from accept to out_valid.
  - 1 instruction/cycle when out_ready held high.
- Held operands are not refreshed by writebacks arriving while stalled. RAW hazards beyond the same-cycle bypass are resolved by the hazard unit upstream.
- A simultaneous writeback and accept to the same register returns the new wb_data (bypass), and the array is also updated that edge.
- Width rules:
  - No arithmetic in this block.
  - imm is taken as-is (already DATA_WIDTH).
  - Index compares use the full ADDR_WIDTH.

Test Plan:
- Reset:
  - Assert rst mid-transaction with out_valid=1 -> out_valid=0 and data_r1=data_r2=0 immediately, before the next edge.
  - After release, a read of x5 -> 0.
- Write then read:
  - wb_en=1, wb_addr=3, wb_data=0x0000000E one cycle.
  - Next cycle accept rs1=3, rs2=0, use_imm=0, alu_ctrl_in=1.
  - One edge later -> out_valid=1, data_r1=0x0000000E, data_r2=0, ALUControl=1.
- x0 protection:
  - Write wb_addr=0, wb_data=0xFFFFFFFF.
  - Then accept rs1=0 -> data_r1=0.
- Same-cycle bypass:
  - x4=0x1, then in one cycle wb_en=1, wb_addr=4, wb_data=0x0000000F while accepting rs2=4, use_imm=0.
  - Next edge -> data_r2=0x0000000F; a subsequent read of x4 -> 0x0000000F.
- Backpressure:
  - Accept A (rs1=3 -> 0xE); hold out_ready=0 for 3 cycles while presenting B -> in_ready=0 and outputs stay A for all 3 cycles.
  - Raise out_ready -> B latched next edge, out_valid stays 1.
- Immediate select:
  - use_imm=1, imm=0xFFFFFFF0, rs2=3 -> data_r2=0xFFFFFFF0.
  - Stream 4 instructions with out_ready=1 -> out_valid high 4 consecutive cycles, then 0.
